// File: rtl/block_pkg.sv
// Shared types and constants for the 8x8 block serializer datapath.
// Holds block geometry, the ProRes progressive scan table and the fill-state encoding.
package block_pkg;

    localparam int BLOCK_DIM    = 8;
    localparam int BLOCK_PIXELS = 64;
    localparam int SAMPLE_WIDTH = 32;

    typedef logic [5:0] block_idx_t;
    typedef logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][SAMPLE_WIDTH-1:0] block_array_t;

    // Buffer occupancy doubles as the only state machine in the block.
    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_state_e;

    // Raster index visited at each scan position.
    localparam block_idx_t PRORES_PROG_SCAN [BLOCK_PIXELS] = '{
        6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
        6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
        6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
        6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
        6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
        6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
        6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/block_pingpong_buf.sv
// Two-entry ping-pong storage for 8x8 blocks with write/read pointers and fill count.
// A whole block is written in one cycle; one sample is read combinationally by raster index.
module block_pingpong_buf
    import block_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                                            clock,
    input  logic                                            reset_n,
    input  logic                                            wr_valid_i,
    input  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][DATA_WIDTH-1:0] wr_block_i,
    input  logic                                            rd_done_i,
    input  block_idx_t                                      rd_idx_i,
    output logic [DATA_WIDTH-1:0]                           rd_data_o,
    output logic                                            not_full_o,
    output logic                                            not_empty_o
);

    fill_state_e state_q, state_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        accept;
    logic        complete;

    logic [DATA_WIDTH-1:0] mem_q [2][BLOCK_PIXELS];

    assign not_full_o  = (state_q != FILL_FULL);
    assign not_empty_o = (state_q != FILL_EMPTY);
    assign accept      = wr_valid_i && not_full_o;
    assign complete    = rd_done_i && not_empty_o;
    assign rd_data_o   = mem_q[rd_ptr_q][rd_idx_i];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FILL_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample storage is deliberately left unreset; occupancy alone says what is valid.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int r = 0; r < BLOCK_DIM; r++) begin
                for (int c = 0; c < BLOCK_DIM; c++) begin
                    mem_q[wr_ptr_q][r*BLOCK_DIM + c] <= wr_block_i[r][c];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept)   wr_ptr_d = ~wr_ptr_q;
        if (complete) rd_ptr_d = ~rd_ptr_q;
        unique case (state_q)
            FILL_EMPTY: if (accept) state_d = FILL_ONE;
            FILL_ONE: begin
                if (accept && !complete)      state_d = FILL_FULL;
                else if (!accept && complete) state_d = FILL_EMPTY;
            end
            FILL_FULL:  if (complete) state_d = FILL_ONE;
            default:    state_d = FILL_EMPTY;
        endcase
    end

endmodule

// File: rtl/block_serializer.sv
// Loads whole 8x8 blocks and streams them out one sample per beat with index and last flag.
// Define BLOCK_SERIALIZER_SCAN_ORDER_EN to emit in ProRes progressive scan order instead of raster.
module block_serializer
    import block_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int BLOCK_CNT_WIDTH = 32
) (
    input  logic                                            clock,
    input  logic                                            reset_n,
    input  logic                                            input_valid,
    output logic                                            input_ready,
    input  logic [BLOCK_DIM-1:0][BLOCK_DIM-1:0][DATA_WIDTH-1:0] input_data_array,
    output logic                                            output_valid,
    input  logic                                            output_ready,
    output logic [DATA_WIDTH-1:0]                           output_data,
    output logic [5:0]                                      output_index,
    output logic                                            output_last,
    output logic [BLOCK_CNT_WIDTH-1:0]                      block_count
);

    block_idx_t                 sp_q, sp_d;
    logic [BLOCK_CNT_WIDTH-1:0] block_count_q, block_count_d;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       beat;
    logic                       block_done;

    function automatic block_idx_t scan_pos(input block_idx_t sp);
`ifdef BLOCK_SERIALIZER_SCAN_ORDER_EN
        return PRORES_PROG_SCAN[sp];
`else
        return sp;
`endif
    endfunction

    block_pingpong_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_valid_i  (input_valid),
        .wr_block_i  (input_data_array),
        .rd_done_i   (block_done),
        .rd_idx_i    (output_index),
        .rd_data_o   (rd_data),
        .not_full_o  (input_ready),
        .not_empty_o (output_valid)
    );

    assign output_index = scan_pos(sp_q);
    assign output_last  = output_valid && (sp_q == 6'd63);
    assign beat         = output_valid && output_ready;
    assign block_done   = beat && (sp_q == 6'd63);
    // Storage is never reset, so mask the sample whenever nothing is held.
    assign output_data  = output_valid ? rd_data : '0;
    assign block_count  = block_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sp_q          <= '0;
            block_count_q <= '0;
        end else begin
            sp_q          <= sp_d;
            block_count_q <= block_count_d;
        end
    end

    always_comb begin
        sp_d          = sp_q;
        block_count_d = block_count_q;
        if (beat)       sp_d          = sp_q + 6'd1;
        if (block_done) block_count_d = block_count_q + BLOCK_CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_block_serializer.sv
// Scoreboard bench for block_serializer: random blocks and output backpressure against a queue model.
// Expected beats are queued at each accept; a negedge monitor pops and compares every output beat.
module tb_block_serializer;

    localparam int DW   = 32;
    localparam int CNTW = 4;

    typedef logic [7:0][7:0][DW-1:0] blk_t;
    typedef struct {
        logic [DW-1:0] data;
        logic [5:0]    index;
        logic          last;
    } beat_t;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            input_valid;
    logic            input_ready;
    blk_t            input_data_array;
    logic            output_valid;
    logic            output_ready;
    logic [DW-1:0]   output_data;
    logic [5:0]      output_index;
    logic            output_last;
    logic [CNTW-1:0] block_count;

    beat_t           sb[$];
    int              checks = 0;
    int              failures = 0;
    int              beats = 0;
    int              readyMode = 0;
    int              phase = 0;
    logic [CNTW-1:0] expBlocks = '0;
    int              scanOrder [64];

    logic            prevStall = 1'b0;
    logic [DW-1:0]   prevData;
    logic [5:0]      prevIndex;
    logic            prevLast;

    block_serializer #(
        .DATA_WIDTH      (DW),
        .BLOCK_CNT_WIDTH (CNTW)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .input_valid      (input_valid),
        .input_ready      (input_ready),
        .input_data_array (input_data_array),
        .output_valid     (output_valid),
        .output_ready     (output_ready),
        .output_data      (output_data),
        .output_index     (output_index),
        .output_last      (output_last),
        .block_count      (block_count)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pushBlock(input blk_t b);
        beat_t e;
        for (int k = 0; k < 64; k++) begin
            e.index = 6'(scanOrder[k]);
            e.data  = b[scanOrder[k] / 8][scanOrder[k] % 8];
            e.last  = (k == 63);
            sb.push_back(e);
        end
    endtask

    function automatic blk_t rampBlock(input int base);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = DW'(base + r*8 + c);
        return b;
    endfunction

    function automatic blk_t randBlock();
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = $urandom;
        return b;
    endfunction

    // Offer a block until accepted; the model learns of it just after the accepting edge is decided.
    task automatic applyStimulus(input blk_t b);
        bit ok = 0;
        input_data_array = b;
        input_valid      = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            if (input_ready) ok = 1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got input_ready=0 expected 1 within 3000 cycles");
        end else begin
            #1 pushBlock(b);
        end
        @(posedge clock);
        #1;
        input_valid      = 1'b0;
        input_data_array = randBlock();
    endtask

    task automatic waitDrain();
        bit done = 0;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clock);
            if (sb.size() == 0) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: got %0d pending beats expected 0", sb.size());
        end
        @(negedge clock);
        checkOutput("drained_valid", 64'(output_valid), 64'd0);
        @(posedge clock);
        #1;
    endtask

    always @(posedge clock) begin
        #1;
        case (readyMode)
            0:       output_ready = 1'b1;
            1:       begin output_ready = (phase % 4 == 0) || (phase % 4 == 3); phase++; end
            default: output_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: handshake flags from the model's occupancy, stall stability, beat contents.
    always @(negedge clock) begin
        beat_t e;
        if (!reset_n) begin
            prevStall = 1'b0;
        end else begin
            checkOutput("input_ready", 64'(input_ready), 64'((sb.size() + 63) / 64 < 2));
            checkOutput("output_valid", 64'(output_valid), 64'(sb.size() > 0));
            checkOutput("block_count", 64'(block_count), 64'(expBlocks));
            if (prevStall) begin
                checkOutput("stall_data", 64'(output_data), 64'(prevData));
                checkOutput("stall_index", 64'(output_index), 64'(prevIndex));
                checkOutput("stall_last", 64'(output_last), 64'(prevLast));
            end
            if (output_valid && output_ready && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("beat_data", 64'(output_data), 64'(e.data));
                checkOutput("beat_index", 64'(output_index), 64'(e.index));
                checkOutput("beat_last", 64'(output_last), 64'(e.last));
                beats++;
                if (e.last) expBlocks = expBlocks + 1'b1;
            end else if (!output_valid) begin
                checkOutput("idle_data", 64'(output_data), 64'd0);
                checkOutput("idle_last", 64'(output_last), 64'd0);
            end
            prevStall = output_valid && !output_ready;
            prevData  = output_data;
            prevIndex = output_index;
            prevLast  = output_last;
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 64'(output_valid), 64'd0);
        checkOutput({tag, "_ready"}, 64'(input_ready), 64'd1);
        checkOutput({tag, "_count"}, 64'(block_count), 64'd0);
        checkOutput({tag, "_data"}, 64'(output_data), 64'd0);
        checkOutput({tag, "_index"}, 64'(output_index), 64'd0);
        checkOutput({tag, "_last"}, 64'(output_last), 64'd0);
    endtask

    initial begin
        int b0;
        bit hit;
`ifdef BLOCK_SERIALIZER_SCAN_ORDER_EN
        int prores [64] = '{
            0, 1, 8, 9, 2, 3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
            4, 5, 12, 20, 13, 6, 7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
            32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
            51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
        for (int k = 0; k < 64; k++) scanOrder[k] = prores[k];
`else
        for (int k = 0; k < 64; k++) scanOrder[k] = k;
`endif
        reset_n          = 1'b0;
        input_valid      = 1'b0;
        output_ready     = 1'b1;
        input_data_array = '0;
        #1 checkResetOutputs("reset");
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;

        $display("[TB] single ramp block");
        applyStimulus(rampBlock(100));
        waitDrain();
        checkOutput("single_count", 64'(block_count), 64'd1);

        $display("[TB] back-to-back blocks");
        applyStimulus(rampBlock(0));
        applyStimulus(rampBlock(1000));
        waitDrain();

        $display("[TB] output backpressure");
        readyMode = 1;
        applyStimulus(randBlock());
        waitDrain();

        $display("[TB] reset mid-block");
        readyMode = 0;
        applyStimulus(rampBlock(7000));
        b0  = beats;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clock);
            #1;
            if (beats >= b0 + 20) hit = 1;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("[TB] FAIL midreset_wait: got %0d beats expected 20", beats - b0);
        end
        reset_n = 1'b0;
        sb.delete();
        expBlocks = '0;
        #1 checkResetOutputs("midreset");
        @(posedge clock);
        #1 reset_n = 1'b1;

        $display("[TB] post-reset block and counter wrap");
        applyStimulus(rampBlock(500));
        readyMode = 2;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 20)) @(posedge clock);
                #1;
            end
            applyStimulus(randBlock());
        end
        waitDrain();
        checkOutput("wrap_count", 64'(block_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
